seg_serial_driver: RTL and testbench

//   Serial 8-digit 7-segment display driver downstream of the pipelined CPU core's debug-value mux.

---
 rtl/seg_serial_driver.sv | 151 +++++++++++++++
 tb/tb_seg_serial_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_driver.sv
// Serial driver for an 8-digit 7-segment display chain: encodes a 32-bit hex
// word plus dp/blank masks into a 64-bit frame and shifts it out MSB first.
module seg_serial_driver #(
  parameter int CLK_DIV        = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_clr,
  output logic        seg_dt,
  output logic        seg_en,
  output logic [1:0]  state_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Digit k lands in frame[8k+7:8k], so digit7 occupies the MSB byte.
  function automatic logic [63:0] build_frame(input logic [31:0] d,
                                              input logic [7:0]  dp,
                                              input logic [7:0]  bl);
    logic [7:0] b;
    build_frame = '0;
    for (int k = 0; k < 8; k++) begin
      b = bl[k] ? 8'h00 : {dp[k], hex7(d[4*k +: 4])};
      build_frame[8*k +: 8] = SEG_ACTIVE_LOW ? ~b : b;
    end
  endfunction

  state_t        state_q, state_d;
  logic [63:0]   frame_q, frame_d;
  logic [5:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          seg_clk_q, seg_clk_d;
  logic          seg_dt_q, seg_dt_d;
  logic          seg_clr_q, seg_clr_d;
  logic          seg_en_q, seg_en_d;
  logic [63:0]   frame_new;

  assign frame_new = build_frame(data, dp_mask, blank_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      seg_clk_q <= 1'b0;
      seg_dt_q  <= 1'b0;
      seg_clr_q <= 1'b0;
      seg_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      seg_clk_q <= seg_clk_d;
      seg_dt_q  <= seg_dt_d;
      seg_clr_q <= seg_clr_d;
      seg_en_q  <= seg_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    div_d     = div_q;
    seg_clk_d = seg_clk_q;
    seg_dt_d  = seg_dt_q;
    seg_clr_d = 1'b1;
    seg_en_d  = seg_en_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d   = S_SHIFT;
          frame_d   = frame_new;
          bit_d     = 6'd63;
          div_d     = '0;
          seg_clk_d = 1'b0;
          seg_dt_d  = frame_new[63];
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!seg_clk_q) begin
            seg_clk_d = 1'b1;
          end else begin
            // End of a high phase: next bit goes out on the falling edge.
            seg_clk_d = 1'b0;
            if (bit_q == 6'd0) begin
              state_d  = S_DONE;
              seg_en_d = 1'b1;
            end else begin
              bit_d    = bit_q - 6'd1;
              seg_dt_d = frame_q[bit_q - 6'd1];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign seg_clk = seg_clk_q;
  assign seg_dt  = seg_dt_q;
  assign seg_clr = seg_clr_q;
  assign seg_en  = seg_en_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: two instances (active-low CLK_DIV=2, active-high
// CLK_DIV=1) whose shifted frames are compared against a digit-level model.
`timescale 1ns/1ps
module tb_seg_serial_driver;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [7:0]  dp_a = '0, dp_b = '0, bl_a = '0, bl_b = '0;
  logic        busy_a, done_a, sclk_a, sclr_a, sdt_a, sen_a;
  logic        busy_b, done_b, sclk_b, sclr_b, sdt_b, sen_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int fails  = 0;

  seg_serial_driver #(.CLK_DIV(2), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .data(data_a),
    .dp_mask(dp_a), .blank_mask(bl_a), .busy(busy_a), .done(done_a),
    .seg_clk(sclk_a), .seg_clr(sclr_a), .seg_dt(sdt_a), .seg_en(sen_a),
    .state_o(st_a)
  );

  seg_serial_driver #(.CLK_DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .data(data_b),
    .dp_mask(dp_b), .blank_mask(bl_b), .busy(busy_b), .done(done_b),
    .seg_clk(sclk_b), .seg_clr(sclr_b), .seg_dt(sdt_b), .seg_en(sen_b),
    .state_o(st_b)
  );

  always #5 clk = ~clk;

  // Receiver model: sample seg_dt whenever seg_clk has risen.
  logic rx_a[$];
  logic rx_b[$];
  int   done_cnt_a = 0;
  int   dt_viol = 0;
  logic prev_clk_a = 0, prev_clk_b = 0, prev_dt_a = 0, prev_busy_a = 0, prev_rst = 0;

  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (sclk_a && !prev_clk_a) rx_a.push_back(sdt_a);
      if (sclk_b && !prev_clk_b) rx_b.push_back(sdt_b);
      if (done_a) done_cnt_a++;
      if ((sdt_a !== prev_dt_a) && !(prev_clk_a && !sclk_a) && !(!prev_busy_a && busy_a))
        dt_viol++;
    end
    prev_clk_a  = sclk_a;
    prev_clk_b  = sclk_b;
    prev_dt_a   = sdt_a;
    prev_busy_a = busy_a;
    prev_rst    = rst_n;
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] d, input logic [7:0] dp,
                                          input logic [7:0] bl, input int k, input bit al);
    logic [3:0] nib;
    logic [7:0] b;
    nib = 4'((d >> (4 * k)) & 32'hF);
    if (bl[k]) b = 8'h00;
    else b = {dp[k], SEG_TAB[nib]};
    if (al) b = ~b;
    return b;
  endfunction

  task automatic check_frame(input bit sel, input int base, input logic [31:0] d,
                             input logic [7:0] dp, input logic [7:0] bl, input string name);
    int n;
    logic [7:0] got, exp;
    n = sel ? rx_b.size() - base : rx_a.size() - base;
    checks++;
    if (n !== 64) begin
      fails++;
      $display("FAIL %s bitcount: got %0d want 64", name, n);
    end else begin
      for (int j = 0; j < 8; j++) begin
        got = '0;
        for (int b = 0; b < 8; b++) got = {got[6:0], sel ? rx_b[base + 8*j + b] : rx_a[base + 8*j + b]};
        exp = exp_byte(d, dp, bl, 7 - j, !sel);
        checks++;
        if (got !== exp) begin
          fails++;
          $display("FAIL %s byte%0d: got %02h want %02h", name, j, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #22;
    checks++;
    if ({busy_a, done_a, sclk_a, sdt_a, sclr_a, sen_a, st_a} !== 8'h00 ||
        {busy_b, done_b, sclk_b, sdt_b, sclr_b, sen_b, st_b} !== 8'h00) begin
      fails++;
      $display("FAIL reset_vals: a=%b%b%b%b%b%b%b b=%b%b%b%b%b%b%b want all 0",
               busy_a, done_a, sclk_a, sdt_a, sclr_a, sen_a, st_a,
               busy_b, done_b, sclk_b, sdt_b, sclr_b, sen_b, st_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sclr_a !== 1'b1 || sclr_b !== 1'b1) begin
      fails++;
      $display("FAIL reset_clr: got %b%b want 11", sclr_a, sclr_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || sen_a !== 1'b0 || st_a !== 2'd0 || sclr_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: busy=%b en=%b st=%0d clr=%b want 0 0 0 1", busy_a, sen_a, st_a, sclr_a);
    end
  endtask

  task automatic run_frame_a(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                             input bit reject, input string name);
    int base, dbase, done_at;
    base = rx_a.size();
    dbase = done_cnt_a;
    done_at = -1;
    @(negedge clk);
    data_a = d; dp_a = dp; bl_a = bl; load_a = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) begin
        load_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
          fails++;
          $display("FAIL %s busy_start: got %b want 1", name, busy_a);
        end
      end
      if (reject && i == 60) begin load_a = 1'b1; data_a = ~d; end
      if (reject && i == 61) load_a = 1'b0;
      if (done_a === 1'b1 && done_at < 0) begin
        done_at = i;
        checks++;
        if (busy_a !== 1'b0) begin
          fails++;
          $display("FAIL %s busy_in_done: got %b want 0", name, busy_a);
        end
        if (reject) begin load_a = 1'b1; data_a = ~d; end
      end
      if (reject && done_at > 0 && i == done_at + 1) load_a = 1'b0;
      if (done_at > 0 && i >= done_at + 5) break;
    end
    load_a = 1'b0;
    checks++;
    if (done_at !== 257) begin
      fails++;
      $display("FAIL %s done_latency: got %0d want 257", name, done_at);
    end
    checks++;
    if (done_cnt_a - dbase !== 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt_a - dbase);
    end
    checks++;
    if (sen_a !== 1'b1 || busy_a !== 1'b0 || sclk_a !== 1'b0) begin
      fails++;
      $display("FAIL %s after_frame: en=%b busy=%b sclk=%b want 1 0 0", name, sen_a, busy_a, sclk_a);
    end
    check_frame(1'b0, base, d, dp, bl, name);
  endtask

  task automatic test_basic();
    run_frame_a(32'h01234567, 8'h00, 8'h00, 1'b0, "basic");
  endtask

  task automatic test_masks();
    run_frame_a(32'hFFFFFFFF, 8'h01, 8'h80, 1'b0, "masks");
    run_frame_a($urandom, 8'($urandom), 8'($urandom), 1'b0, "rand_masks");
  endtask

  task automatic test_busy_reject();
    run_frame_a($urandom, 8'($urandom), 8'h00, 1'b1, "reject");
    run_frame_a($urandom, 8'h00, 8'($urandom), 1'b0, "after_reject");
  endtask

  task automatic test_reset_mid();
    int base, dbase;
    bit hit;
    base = rx_a.size();
    dbase = done_cnt_a;
    hit = 1'b0;
    @(negedge clk);
    data_a = $urandom; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_a.size() - base > 20) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL midrst_progress: got %0d bits want >20", rx_a.size() - base);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sclk_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || st_a !== 2'd0 || sen_a !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: sclk=%b busy=%b done=%b st=%0d en=%b want 0", sclk_a, busy_a, done_a, st_a, sen_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt_a !== dbase || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL midrst_no_done: dones=%0d busy=%b want 0 0", done_cnt_a - dbase, busy_a);
    end
    run_frame_a($urandom, 8'($urandom), 8'($urandom), 1'b0, "fresh");
  endtask

  task automatic run_frame_b(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                             input string name);
    int base, done_at;
    base = rx_b.size();
    done_at = -1;
    @(negedge clk);
    data_b = d; dp_b = dp; bl_b = bl; load_b = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      load_b = 1'b0;
      if (done_b === 1'b1) begin done_at = i; break; end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_at !== 129) begin
      fails++;
      $display("FAIL %s done_latency: got %0d want 129", name, done_at);
    end
    check_frame(1'b1, base, d, dp, bl, name);
  endtask

  task automatic test_polarity();
    run_frame_b(32'h88888888, 8'h00, 8'h00, "polarity");
    run_frame_b($urandom, 8'($urandom), 8'($urandom), "pol_rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masks();
    test_busy_reject();
    test_reset_mid();
    test_polarity();
    checks++;
    if (dt_viol !== 0) begin
      fails++;
      $display("FAIL dt_timing: got %0d illegal seg_dt changes want 0", dt_viol);
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
